// File: rtl/dot_product_sequencer_pkg.sv
// Shared constants and FSM encoding for the dot-product blocks (sequential and parallel).
package dot_product_sequencer_pkg;

   localparam int DP_DATA_W  = 8;
   localparam int DP_ACC_W   = 16;
   localparam int DP_MAX_LEN = 4;
   localparam int DP_LEN_W   = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ACCUM = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/dot_product_sequencer_mac.sv
// Combinational multiply-accumulate: acc_out = acc_in + a*b modulo 2^ACC_W,
// ovf set when the exact sum does not fit in ACC_W bits.
module mac_unit #(
   parameter int DATA_W = 8,
   parameter int ACC_W  = 16
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [ACC_W-1:0]  acc_in,
   output logic [ACC_W-1:0]  acc_out,
   output logic              ovf
);

   // Wide enough for the full product and one carry bit past the accumulator.
   localparam int PW = 2 * DATA_W;
   localparam int SW = ((PW > ACC_W) ? PW : ACC_W) + 1;

   logic [SW-1:0] prod_s;
   logic [SW-1:0] sum_s;

   assign prod_s  = SW'(a) * SW'(b);
   assign sum_s   = SW'(acc_in) + prod_s;
   assign acc_out = sum_s[ACC_W-1:0];
   assign ovf     = |sum_s[SW-1:ACC_W];

endmodule

// File: rtl/dot_product_sequencer.sv
// Time-multiplexed unsigned dot product: one MAC, element pairs streamed over valid/ready,
// result returned over valid/ready with a sticky overflow flag.
module dot_product_sequencer
   import dot_product_sequencer_pkg::*;
#(
   parameter int DATA_W  = DP_DATA_W,
   parameter int ACC_W   = DP_ACC_W,
   parameter int MAX_LEN = DP_MAX_LEN,
   parameter int LEN_W   = DP_LEN_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic [LEN_W-1:0]  len,
   output logic              busy,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] a_in,
   input  logic [DATA_W-1:0] b_in,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [ACC_W-1:0]  result,
   output logic              overflow
);

   state_t            state_r, state_nx_s;
   logic [ACC_W-1:0]  acc_r, mac_acc_s;
   logic              ovf_r, mac_ovf_s;
   logic [LEN_W-1:0]  count_r;
   logic              busy_r, in_ready_r, res_valid_r;
   logic              load_s, zero_job_s, accept_s;

   mac_unit #(.DATA_W(DATA_W), .ACC_W(ACC_W)) u_mac (
      .a       (a_in),
      .b       (b_in),
      .acc_in  (acc_r),
      .acc_out (mac_acc_s),
      .ovf     (mac_ovf_s)
   );

   // Next-state and datapath control decode.
   always_comb begin
      state_nx_s = state_r;
      load_s     = 1'b0;
      zero_job_s = 1'b0;
      accept_s   = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (start) begin
               if (len == LEN_W'(0)) begin
                  zero_job_s = 1'b1;
                  state_nx_s = ST_DONE;
               end else if (int'(len) <= MAX_LEN) begin
                  load_s     = 1'b1;
                  state_nx_s = ST_ACCUM;
               end else begin
                  state_nx_s = ST_IDLE;
               end
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_ACCUM: begin
            if (in_valid) begin
               accept_s = 1'b1;
               if (count_r == LEN_W'(1)) begin
                  state_nx_s = ST_DONE;
               end else begin
                  state_nx_s = ST_ACCUM;
               end
            end else begin
               state_nx_s = ST_ACCUM;
            end
         end
         ST_DONE: begin
            if (res_ready) begin
               state_nx_s = ST_IDLE;
            end else begin
               state_nx_s = ST_DONE;
            end
         end
         default: begin
            state_nx_s = ST_IDLE;
         end
      endcase
   end

   // State, accumulator, counter and handshake outputs; status flags are registered from next state.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r     <= ST_IDLE;
         acc_r       <= {ACC_W{1'b0}};
         ovf_r       <= 1'b0;
         count_r     <= {LEN_W{1'b0}};
         busy_r      <= 1'b0;
         in_ready_r  <= 1'b0;
         res_valid_r <= 1'b0;
      end else begin
         state_r     <= state_nx_s;
         busy_r      <= (state_nx_s != ST_IDLE);
         in_ready_r  <= (state_nx_s == ST_ACCUM);
         res_valid_r <= (state_nx_s == ST_DONE);
         if (load_s || zero_job_s) begin
            acc_r <= {ACC_W{1'b0}};
            ovf_r <= 1'b0;
         end else if (accept_s) begin
            acc_r <= mac_acc_s;
            ovf_r <= ovf_r | mac_ovf_s;
         end
         if (load_s) begin
            count_r <= len;
         end else if (accept_s) begin
            count_r <= count_r - LEN_W'(1);
         end
      end
   end

   assign busy      = busy_r;
   assign in_ready  = in_ready_r;
   assign res_valid = res_valid_r;
   assign result    = acc_r;
   assign overflow  = ovf_r;

endmodule

// File: tb/tb_dot_product_sequencer.sv
// Directed bench for dot_product_sequencer: stimulus pushes expected results into a
// scoreboard queue, a negedge monitor checks every presented result against it.
module tb_dot_product_sequencer;

   localparam int DATA_W = 8;
   localparam int ACC_W  = 16;
   localparam int LEN_W  = 3;

   typedef struct {
      logic [ACC_W-1:0] res;
      logic             ovf;
      int               cyc;
   } exp_t;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              start = 1'b0;
   logic [LEN_W-1:0]  len = '0;
   logic              busy;
   logic              in_valid = 1'b0;
   logic              in_ready;
   logic [DATA_W-1:0] a_in = '0;
   logic [DATA_W-1:0] b_in = '0;
   logic              res_valid;
   logic              res_ready = 1'b1;
   logic [ACC_W-1:0]  result;
   logic              overflow;

   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;
   int   start_cyc = 0;
   logic rv_prev = 1'b0;
   exp_t sb[$];

   dot_product_sequencer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .len       (len),
      .busy      (busy),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a_in      (a_in),
      .b_in      (b_in),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .result    (result),
      .overflow  (overflow)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_job(input int n);
      start     = 1'b1;
      len       = LEN_W'(n);
      start_cyc = cyc;
      step();
      start     = 1'b0;
   endtask

   task automatic expect_res(input int res, input logic ovf, input int lat);
      exp_t e;
      e.res = ACC_W'(res);
      e.ovf = ovf;
      e.cyc = start_cyc + lat;
      sb.push_back(e);
   endtask

   task automatic feed(input int a, input int b);
      logic ok;
      in_valid = 1'b1;
      a_in     = DATA_W'(a);
      b_in     = DATA_W'(b);
      ok       = 1'b0;
      for (int k = 0; k < 20; k++) begin
         ok = in_ready;
         step();
         if (ok) break;
      end
      in_valid = 1'b0;
      if (!ok) chk("feed_timeout", 0, 1);
   endtask

   task automatic drain();
      for (int k = 0; k < 40; k++) begin
         if (sb.size() == 0) break;
         step();
      end
      chk("drain", sb.size(), 0);
   endtask

   task automatic check_idle_zero(input string tag);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_in_ready"}, int'(in_ready), 0);
      chk({tag, "_res_valid"}, int'(res_valid), 0);
      chk({tag, "_result"}, int'(result), 0);
      chk({tag, "_overflow"}, int'(overflow), 0);
   endtask

   // Scoreboard monitor: checks latency on the rising edge of res_valid, value every valid cycle.
   always @(negedge clk) begin
      if (res_valid) begin
         if (sb.size() == 0) begin
            chk("unexpected_res_valid", 1, 0);
         end else begin
            if (!rv_prev) chk("res_latency", cyc, sb[0].cyc);
            chk("result", int'(result), int'(sb[0].res));
            chk("overflow", int'(overflow), int'(sb[0].ovf));
            if (res_ready) void'(sb.pop_front());
         end
      end
      rv_prev = res_valid;
   end

   initial begin
      int k;
      step();
      step();
      check_idle_zero("reset");
      rst_n = 1'b1;
      step();

      // 1,2,3,4 . 1,2,3,4 = 30, in_valid held high
      start_job(4);
      expect_res(30, 1'b0, 5);
      for (int i = 1; i <= 4; i++) feed(i, i);
      drain();

      // Same vectors, 2-cycle bubble between elements 2 and 3
      start_job(4);
      expect_res(30, 1'b0, 7);
      feed(1, 1);
      feed(2, 2);
      chk("bubble_in_ready0", int'(in_ready), 1);
      step();
      chk("bubble_in_ready1", int'(in_ready), 1);
      step();
      feed(3, 3);
      feed(4, 4);
      drain();

      // All 255: 260100 mod 65536 = 63492, overflow
      start_job(4);
      expect_res(63492, 1'b1, 5);
      for (int i = 0; i < 4; i++) feed(255, 255);
      drain();

      // len = 0 -> result 0 next cycle
      start_job(0);
      expect_res(0, 1'b0, 1);
      drain();

      // len = 5 -> ignored
      start_job(5);
      chk("len5_busy0", int'(busy), 0);
      step();
      chk("len5_busy1", int'(busy), 0);
      chk("len5_in_ready", int'(in_ready), 0);

      // Back-pressure in DONE with start pulses ignored: [3].[3] = 9
      res_ready = 1'b0;
      start_job(1);
      expect_res(9, 1'b0, 2);
      feed(3, 3);
      k = 0;
      while (!res_valid && k < 20) begin
         step();
         k++;
      end
      for (int i = 0; i < 3; i++) begin
         start = 1'b1;
         len   = LEN_W'(2);
         step();
         chk("hold_res_valid", int'(res_valid), 1);
         chk("hold_busy", int'(busy), 1);
      end
      start     = 1'b0;
      res_ready = 1'b1;
      drain();
      step();
      chk("after_hold_busy", int'(busy), 0);

      // [2,3].[4,5] = 23
      start_job(2);
      expect_res(23, 1'b0, 3);
      feed(2, 4);
      feed(3, 5);
      drain();

      // Reset after 2 of 4 elements: no result, outputs cleared
      start_job(4);
      feed(1, 1);
      feed(2, 2);
      chk("pre_reset_result", int'(result), 5);
      rst_n = 1'b0;
      step();
      check_idle_zero("midjob_reset");
      rst_n = 1'b1;
      step();

      // Fresh job: [7].[9] = 63
      start_job(1);
      expect_res(63, 1'b0, 2);
      feed(7, 9);
      drain();
      step();
      step();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/dot_product_sequencer.md
Name: dot_product_sequencer

Overview:
Time-multiplexed dot-product engine. It computes the dot product of two unsigned vectors of programmable length using a single multiply-accumulate unit instead of a parallel multiplier tree. It accepts a job on a start pulse and consumes element pairs over a valid/ready stream. It returns the sum on a valid/ready result port and sits between a vector source (memory reader or host) and the result consumer.

Parameters:
DATA_W, 8, width of each unsigned vector element.
ACC_W, 16, width of accumulator and result.
MAX_LEN, 4, maximum vector length per job.
LEN_W, 3, width of len port; must hold MAX_LEN.

Ports:
clk  in  1  single clock, all logic on rising edge.
rst_n  in  1  synchronous active-low reset.
start  in  1  job request pulse; sampled only in IDLE.
len  in  LEN_W  element count for the job; sampled with start.
busy  out  1  high whenever state != IDLE.
in_valid  in  1  element pair a_in/b_in is valid.
in_ready  out  1  sequencer accepts an element this cycle.
a_in  in  DATA_W  element of vector a.
b_in  in  DATA_W  element of vector b.
res_valid  out  1  result and overflow are valid.
res_ready  in  1  consumer accepts result.
result  out  ACC_W  dot product, modulo 2^ACC_W.
overflow  out  1  sticky: a true sum exceeded 2^ACC_W-1 during this job.

Behaviour:
- Reset (rst_n=0 at a clk edge): state=IDLE; busy=0, in_ready=0, res_valid=0, result=0, overflow=0; accumulator and element counter cleared. Reset mid-job discards the partial sum; no result is produced.
- States and transitions:
  - IDLE:
    - start=1 and 1<=len<=MAX_LEN: go to ACCUM; load count=len; clear accumulator and overflow.
    - start=1 and len=0: go to DONE with result=0, overflow=0.
    - start=1 and len>MAX_LEN: job ignored, stay in IDLE.
  - ACCUM: in_ready=1. Each cycle with in_valid&&in_ready: acc <= acc + a_in*b_in (product 2*DATA_W bits, zero-extended or truncated to ACC_W). Set overflow if the addition carries out of ACC_W or the product exceeds ACC_W bits. Decrement count. When the accepted element is the last one (count==1): go to DONE.
  - DONE: res_valid=1; result=acc; in_ready=0. On res_ready=1: go to IDLE. result holds its value until the next job clears it.
- Latency:
  - Last element accepted at cycle t: res_valid=1 from cycle t+1.
  - A len-N job with in_valid held high completes in N+1 cycles from the start edge to res_valid.
  - Back-to-back jobs: start may be accepted the cycle after the res_valid/res_ready handshake, when state is back in IDLE.
- start while busy is ignored. len is not sampled outside IDLE.
- in_valid gaps (bubbles) are permitted; the accumulator and count hold during gaps.
- a_in and b_in are only sampled on an accepted handshake. Elements offered in IDLE or DONE are not consumed.
- res_valid, once high, stays high with stable result and overflow until res_ready.
- Arithmetic is unsigned only; result wraps modulo 2^ACC_W and overflow records the wrap.

Decomposition:
- Shared header (included file), containing:
  - state encoding localparams ST_IDLE=2'd0, ST_ACCUM=2'd1, ST_DONE=2'd2;
  - default DATA_W/ACC_W/MAX_LEN constants shared with the parallel dot-product block.
- Sub-module mac_unit: combinational multiply plus add with carry-out. Inputs: a, b, acc_in. Outputs: acc_out, ovf. The sequencer holds the FSM, counter and registers.

Test Plan:
- Reset, then start with len=4; stream a=[1,2,3,4], b=[1,2,3,4] with in_valid held high -> result=30, overflow=0, res_valid asserted exactly 5 cycles after the start edge.
- Same vectors with in_valid deasserted for 2 cycles between elements 2 and 3 -> result=30; in_ready remains 1; completion delayed by exactly 2 cycles.
- len=4, all elements 255 -> true sum 260100; result=260100 mod 65536=63492, overflow=1.
- len=0 -> res_valid the cycle after start, result=0. Then len=5 -> ignored, busy stays 0.
- Hold res_ready=0 for 3 cycles in DONE -> res_valid and result stable throughout; start pulses during DONE ignored. Next job, len=2 with [2,3]·[4,5] -> 23.
- Assert rst_n=0 after 2 of 4 elements are accepted -> all outputs 0 the next cycle. Then a fresh job len=1, [7]·[9] -> 63 with no residue from the aborted job.
